// File: rtl/cache_coherence_agent_pkg.sv
// Shared encodings for the directory MSI cache agent: line states,
// directory message codes, outgoing request codes and controller states.
package coh_msi_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_M = 2'b10
    } msi_t;

    localparam logic [1:0] MSG_FETCH      = 2'b00;
    localparam logic [1:0] MSG_INV        = 2'b01;
    localparam logic [1:0] MSG_FETCH_INV  = 2'b10;
    localparam logic [1:0] MSG_DATA_REPLY = 2'b11;

    localparam logic [1:0] REQ_READ_MISS  = 2'b00;
    localparam logic [1:0] REQ_WRITE_MISS = 2'b01;
    localparam logic [1:0] REQ_WRITE_BACK = 2'b10;

    typedef enum logic [2:0] {
        CT_IDLE      = 3'd0,
        CT_WB_REQ    = 3'd1,
        CT_MISS_REQ  = 3'd2,
        CT_WAIT_DATA = 3'd3,
        CT_SNP_WB    = 3'd4,
        CT_DONE      = 3'd5
    } ctrl_t;

endpackage

// File: rtl/cache_coherence_agent_if.sv
// CPU, directory-message and directory-request channels of the agent.
// slave = agent side, master = CPU/directory side.
interface cache_coherence_agent_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) ();
    logic              cpu_valid;
    logic              cpu_write;
    logic [TAG_W-1:0]  cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dir_valid;
    logic [1:0]        dir_type;
    logic [TAG_W-1:0]  dir_addr;
    logic [DATA_W-1:0] dir_data;
    logic              dir_ready;

    logic              req_valid;
    logic [1:0]        req_type;
    logic [TAG_W-1:0]  req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;

    modport slave (
        input  cpu_valid, cpu_write, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_done, cpu_rdata,
        input  dir_valid, dir_type, dir_addr, dir_data,
        output dir_ready,
        output req_valid, req_type, req_addr, req_data,
        input  req_ready
    );

    modport master (
        output cpu_valid, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_done, cpu_rdata,
        output dir_valid, dir_type, dir_addr, dir_data,
        input  dir_ready,
        input  req_valid, req_type, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/cache_coherence_agent_msi_hex_decoder.sv
// MSI line state to active-low 7-segment pattern (segment order a..g on [0:6]).
// Also usable by the directory display.
module msi_hex_decoder (
    input  logic [1:0] i_state,
    output logic [0:6] o_seg
);
    // Pure lookup; the unused encoding blanks the display.
    always_comb begin
        o_seg = 7'b1111111;
        case (i_state)
            2'b00:   o_seg = 7'b1001111;
            2'b01:   o_seg = 7'b0100100;
            2'b10:   o_seg = 7'b0110000;
            default: o_seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/cache_coherence_agent.sv
// Cache-side agent for a single-line direct-mapped cache in a directory MSI
// protocol. Serves CPU reads/writes, issues misses and write-backs, and
// answers directory snoops. Optional macro COH_AGENT_HEX_EN adds a 7-seg
// display of the line state on hex_state.
module cache_coherence_agent
    import coh_msi_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    cache_coherence_agent_if.slave bus,
`ifdef COH_AGENT_HEX_EN
    output logic [0:6]             hex_state,
`endif
    output logic [1:0]             line_state
);

    ctrl_t             r_ctrl,       w_ctrl_nxt;
    msi_t              r_line,       w_line_nxt;
    logic [TAG_W-1:0]  r_tag,        w_tag_nxt;
    logic [DATA_W-1:0] r_data,       w_data_nxt;
    logic [TAG_W-1:0]  r_pend_addr,  w_pend_addr_nxt;
    logic              r_pend_write, w_pend_write_nxt;
    logic [DATA_W-1:0] r_pend_wdata, w_pend_wdata_nxt;
    msi_t              r_snp_line,   w_snp_line_nxt;
    ctrl_t             r_snp_ret,    w_snp_ret_nxt;

    logic              w_cpu_ready;
    logic              w_dir_ready;
    logic              w_req_valid;
    logic [1:0]        w_req_type;
    logic [TAG_W-1:0]  w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic              w_snoop;
    logic              w_cpu_hit;
    logic              w_snp_hit;

    assign w_cpu_hit = (r_line != ST_I) && (r_tag == bus.cpu_addr);
    assign w_snp_hit = (r_line != ST_I) && (r_tag == bus.dir_addr);

    // Register all controller and line state; reset clears everything.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ctrl       <= CT_IDLE;
            r_line       <= ST_I;
            r_tag        <= '0;
            r_data       <= '0;
            r_pend_addr  <= '0;
            r_pend_write <= 1'b0;
            r_pend_wdata <= '0;
            r_snp_line   <= ST_I;
            r_snp_ret    <= CT_IDLE;
        end else begin
            r_ctrl       <= w_ctrl_nxt;
            r_line       <= w_line_nxt;
            r_tag        <= w_tag_nxt;
            r_data       <= w_data_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_pend_write <= w_pend_write_nxt;
            r_pend_wdata <= w_pend_wdata_nxt;
            r_snp_line   <= w_snp_line_nxt;
            r_snp_ret    <= w_snp_ret_nxt;
        end
    end

    // Next-state, line update and handshake outputs.
    always_comb begin
        w_ctrl_nxt       = r_ctrl;
        w_line_nxt       = r_line;
        w_tag_nxt        = r_tag;
        w_data_nxt       = r_data;
        w_pend_addr_nxt  = r_pend_addr;
        w_pend_write_nxt = r_pend_write;
        w_pend_wdata_nxt = r_pend_wdata;
        w_snp_line_nxt   = r_snp_line;
        w_snp_ret_nxt    = r_snp_ret;
        w_cpu_ready      = 1'b0;
        w_dir_ready      = 1'b0;
        w_req_valid      = 1'b0;
        w_req_type       = REQ_READ_MISS;
        w_req_addr       = '0;
        w_req_data       = '0;
        w_snoop          = 1'b0;

        case (r_ctrl)
            CT_IDLE: begin
                // Directory traffic has priority so snoops are never starved.
                if (bus.dir_valid) begin
                    w_dir_ready = 1'b1;
                    w_snoop     = 1'b1;
                end else if (bus.cpu_valid) begin
                    w_cpu_ready      = 1'b1;
                    w_pend_addr_nxt  = bus.cpu_addr;
                    w_pend_write_nxt = bus.cpu_write;
                    w_pend_wdata_nxt = bus.cpu_wdata;
                    if (w_cpu_hit && (!bus.cpu_write || r_line == ST_M)) begin
                        if (bus.cpu_write) begin
                            w_data_nxt = bus.cpu_wdata;
                        end
                        w_ctrl_nxt = CT_DONE;
                    end else if (r_line == ST_M && !w_cpu_hit) begin
                        w_ctrl_nxt = CT_WB_REQ;
                    end else begin
                        // Covers true misses and the S->M upgrade.
                        w_ctrl_nxt = CT_MISS_REQ;
                    end
                end
            end
            CT_WB_REQ: begin
                w_req_valid = 1'b1;
                w_req_type  = REQ_WRITE_BACK;
                w_req_addr  = r_tag;
                w_req_data  = r_data;
                if (bus.req_ready) begin
                    w_line_nxt = ST_I;
                    w_ctrl_nxt = CT_MISS_REQ;
                end
            end
            CT_MISS_REQ: begin
                w_req_valid = 1'b1;
                w_req_type  = r_pend_write ? REQ_WRITE_MISS : REQ_READ_MISS;
                w_req_addr  = r_pend_addr;
                if (bus.req_ready) begin
                    w_ctrl_nxt = CT_WAIT_DATA;
                end
            end
            CT_WAIT_DATA: begin
                if (bus.dir_valid) begin
                    w_dir_ready = 1'b1;
                    if (bus.dir_type == MSG_DATA_REPLY && bus.dir_addr == r_pend_addr) begin
                        w_tag_nxt  = r_pend_addr;
                        w_data_nxt = r_pend_write ? r_pend_wdata : bus.dir_data;
                        w_line_nxt = r_pend_write ? ST_M : ST_S;
                        w_ctrl_nxt = CT_DONE;
                    end else begin
                        w_snoop = 1'b1;
                    end
                end
            end
            CT_SNP_WB: begin
                w_req_valid = 1'b1;
                w_req_type  = REQ_WRITE_BACK;
                w_req_addr  = r_tag;
                w_req_data  = r_data;
                if (bus.req_ready) begin
                    w_line_nxt = r_snp_line;
                    w_ctrl_nxt = r_snp_ret;
                end
            end
            CT_DONE: begin
                w_ctrl_nxt = CT_IDLE;
            end
            default: begin
                w_ctrl_nxt = CT_IDLE;
            end
        endcase

        // Snoop effects; stray DATA_REPLYs fall through untouched.
        if (w_snoop && w_snp_hit) begin
            if (r_line == ST_M &&
                (bus.dir_type == MSG_FETCH || bus.dir_type == MSG_FETCH_INV)) begin
                w_snp_line_nxt = (bus.dir_type == MSG_FETCH) ? ST_S : ST_I;
                w_snp_ret_nxt  = r_ctrl;
                w_ctrl_nxt     = CT_SNP_WB;
            end else if (bus.dir_type == MSG_INV) begin
                w_line_nxt = ST_I;
            end
        end
    end

    // Input-dependent handshakes are held low while reset is asserted.
    assign bus.cpu_ready = w_cpu_ready & resetn;
    assign bus.dir_ready = w_dir_ready & resetn;
    assign bus.cpu_done  = (r_ctrl == CT_DONE);
    assign bus.cpu_rdata = (r_ctrl == CT_DONE) ? r_data : '0;
    assign bus.req_valid = w_req_valid;
    assign bus.req_type  = w_req_type;
    assign bus.req_addr  = w_req_addr;
    assign bus.req_data  = w_req_data;
    assign line_state    = r_line;

`ifdef COH_AGENT_HEX_EN
    msi_hex_decoder u_hex (
        .i_state (r_line),
        .o_seg   (hex_state)
    );
`endif

endmodule

// File: tb/tb_cache_coherence_agent.sv
// Directed bench for cache_coherence_agent: scoreboard queues hold expected
// directory requests and CPU completions, compared as the DUT produces them.
module tb_cache_coherence_agent;

    localparam logic [1:0] L_I = 2'b00, L_S = 2'b01, L_M = 2'b10;
    localparam logic [1:0] M_FETCH = 2'b00, M_INV = 2'b01, M_DR = 2'b11;
    localparam logic [1:0] R_RM = 2'b00, R_WM = 2'b01, R_WB = 2'b10;

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] a;
        logic [7:0] d;
    } req_t;

    logic       clock;
    logic       resetn;
    logic [1:0] line_state;
`ifdef COH_AGENT_HEX_EN
    logic [0:6] hex_state;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    req_t       exp_req[$];
    logic [7:0] exp_rd[$];

    cache_coherence_agent_if #(.TAG_W(4), .DATA_W(8)) bus ();

    cache_coherence_agent #(.TAG_W(4), .DATA_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus.slave),
`ifdef COH_AGENT_HEX_EN
        .hex_state  (hex_state),
`endif
        .line_state (line_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_req(input logic wr, input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.cpu_valid = 1'b1;
        bus.cpu_write = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        #1;
        check("cpu_ready", bus.cpu_ready, 1);
        @(negedge clock);
        bus.cpu_valid = 1'b0;
    endtask

    task automatic dir_msg(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.dir_valid = 1'b1;
        bus.dir_type  = t;
        bus.dir_addr  = a;
        bus.dir_data  = d;
        #1;
        check("dir_ready", bus.dir_ready, 1);
        @(negedge clock);
        bus.dir_valid = 1'b0;
    endtask

    task automatic serve_req(input string tag);
        req_t e;
        logic [13:0] first;
        for (int n = 0; n < 30 && !bus.req_valid; n++) @(negedge clock);
        check({tag, "_req_valid"}, bus.req_valid, 1);
        check({tag, "_sb_nonempty"}, exp_req.size() != 0, 1);
        if (exp_req.size() != 0) begin
            e = exp_req.pop_front();
            check({tag, "_req_type"}, bus.req_type, e.t);
            check({tag, "_req_addr"}, bus.req_addr, e.a);
            check({tag, "_req_data"}, bus.req_data, e.d);
        end
        first = {bus.req_type, bus.req_addr, bus.req_data};
        @(negedge clock);
        check({tag, "_req_held"}, {bus.req_valid, bus.req_type, bus.req_addr, bus.req_data},
              {1'b1, first});
        bus.req_ready = 1'b1;
        @(negedge clock);
        bus.req_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 30 && !bus.cpu_done; n++) @(negedge clock);
        check({tag, "_cpu_done"}, bus.cpu_done, 1);
        check({tag, "_sb_nonempty"}, exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check({tag, "_rdata"}, bus.cpu_rdata, exp_rd.pop_front());
        @(negedge clock);
        check({tag, "_done_pulse"}, bus.cpu_done, 0);
    endtask

    initial begin
        bus.cpu_valid = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dir_valid = 1'b0; bus.dir_type = '0; bus.dir_addr = '0; bus.dir_data = '0;
        bus.req_ready = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_line", line_state, L_I);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_cpu_done", bus.cpu_done, 0);
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_dir_ready", bus.dir_ready, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
`ifdef COH_AGENT_HEX_EN
        check("rst_hex", hex_state, 7'b1001111);
`endif
        resetn = 1'b1;

        // Read miss from I
        exp_req.push_back('{R_RM, 4'd3, 8'h00});
        exp_rd.push_back(8'hA5);
        cpu_req(1'b0, 4'd3, 8'h00);
        serve_req("rdmiss");
        dir_msg(M_DR, 4'd3, 8'hA5);
        wait_done("rdmiss");
        check("rdmiss_state", line_state, L_S);

        // Upgrade S -> M; write data wins over reply payload
        exp_req.push_back('{R_WM, 4'd3, 8'h00});
        exp_rd.push_back(8'h5A);
        cpu_req(1'b1, 4'd3, 8'h5A);
        serve_req("upgrade");
        dir_msg(M_DR, 4'd3, 8'h77);
        wait_done("upgrade");
        check("upgrade_state", line_state, L_M);

        // Eviction of dirty line
        exp_req.push_back('{R_WB, 4'd3, 8'h5A});
        exp_req.push_back('{R_RM, 4'd7, 8'h00});
        exp_rd.push_back(8'h11);
        cpu_req(1'b0, 4'd7, 8'h00);
        serve_req("evict_wb");
        check("evict_state_I", line_state, L_I);
        serve_req("evict_rm");
        dir_msg(M_DR, 4'd7, 8'h11);
        wait_done("evict");
        check("evict_state", line_state, L_S);

        // Back to M tag3 data 5A (miss from S of another tag)
        exp_req.push_back('{R_WM, 4'd3, 8'h00});
        exp_rd.push_back(8'h5A);
        cpu_req(1'b1, 4'd3, 8'h5A);
        serve_req("wmiss");
        dir_msg(M_DR, 4'd3, 8'h00);
        wait_done("wmiss");
        check("wmiss_state", line_state, L_M);

        // Snoops
        exp_req.push_back('{R_WB, 4'd3, 8'h5A});
        dir_msg(M_FETCH, 4'd3, 8'h00);
        serve_req("fetch");
        check("fetch_state", line_state, L_S);
        dir_msg(M_INV, 4'd3, 8'h00);
        check("inv_state", line_state, L_I);
        dir_msg(M_FETCH, 4'd9, 8'h00);
        check("fetch9_state", line_state, L_I);
        check("fetch9_no_req", bus.req_valid, 0);

        // Upgrade race
        exp_req.push_back('{R_RM, 4'd3, 8'h00});
        exp_rd.push_back(8'h3C);
        cpu_req(1'b0, 4'd3, 8'h00);
        serve_req("race_rd");
        dir_msg(M_DR, 4'd3, 8'h3C);
        wait_done("race_rd");
        exp_req.push_back('{R_WM, 4'd3, 8'h00});
        exp_rd.push_back(8'hC3);
        cpu_req(1'b1, 4'd3, 8'hC3);
        serve_req("race_wm");
        dir_msg(M_INV, 4'd3, 8'h00);
        check("race_inv_state", line_state, L_I);
        check("race_no_done", bus.cpu_done, 0);
        dir_msg(M_DR, 4'd3, 8'h00);
        wait_done("race");
        check("race_state", line_state, L_M);

        // Stray DATA_REPLY in IDLE is dropped, then a read hit in M
        dir_msg(M_DR, 4'd4, 8'hEE);
        check("stray_state", line_state, L_M);
        check("stray_no_done", bus.cpu_done, 0);
        check("stray_no_req", bus.req_valid, 0);
        exp_rd.push_back(8'hC3);
        cpu_req(1'b0, 4'd3, 8'h00);
        wait_done("rdhit");

        // Reset while a write-back request is outstanding
        cpu_req(1'b0, 4'd5, 8'h00);
        #1;
        check("pre_rst_req_valid", bus.req_valid, 1);
        resetn = 1'b0;
        #1;
        check("async_rst_req_valid", bus.req_valid, 0);
        check("async_rst_line", line_state, L_I);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_no_done", bus.cpu_done, 0);
        check("post_rst_no_req", bus.req_valid, 0);
`ifdef COH_AGENT_HEX_EN
        check("post_rst_hex", hex_state, 7'b1001111);
`endif
        check("sb_req_empty", exp_req.size(), 0);
        check("sb_rd_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
